// File: rtl/adc_capture_writer_if.sv
// RAM write port shared between the capture writer and the 2048x14 wave RAM.
// The writer drives the strobe, address and data; the RAM side only listens.
interface adc_capture_writer_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, wr_address, wr_data);
    modport slave  (input  wr_en, wr_address, wr_data);
endinterface

// File: rtl/adc_capture_writer.sv
// ADC capture path: divides clk_400M down to the ADC sample clock, registers samples
// and writes one REC_LEN-entry record into the wave RAM, immediately or on a rising trigger.
module adc_capture_writer #(
    parameter int DATA_W  = 14,
    parameter int ADDR_W  = 11,
    parameter int REC_LEN = 2000
) (
    input  logic               clk_400M,
    input  logic               rst_n,
    input  logic [23:0]        div_in,
    input  logic               start,
    input  logic               trig_en,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic [DATA_W-1:0]  adc_data,
    output logic               adc_clock,
    adc_capture_writer_if.master wr,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, ARM, FILL, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REC_LEN - 1);

    state_t            state;
    logic [23:0]       counter;
    logic [23:0]       div_eff;
    logic              sample_tick;
    logic              sample_valid;
    logic [DATA_W-1:0] sample_reg;
    logic [DATA_W-1:0] prev_reg;
    logic              prev_ok;
    logic [ADDR_W-1:0] address;
    logic              crossing;
    logic              write_hit;

    assign div_eff     = (div_in == 24'd0) ? 24'd1 : div_in;
    assign sample_tick = (counter == div_eff);

    // The >= compare lets a shrinking divider take effect on the very next cycle.
    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update together at the edge, regardless of statement order.
    always_ff @(posedge clk_400M or negedge rst_n) begin
        if (!rst_n) begin
            counter <= 24'd0;
        end else if (counter >= div_eff) begin
            counter <= 24'd0;
        end else begin
            counter <= counter + 24'd1;
        end
    end

    // adc_clock falls on the sampling edge, so the ADC launches new data after capture.
    always_ff @(posedge clk_400M or negedge rst_n) begin
        if (!rst_n) begin
            adc_clock    <= 1'b0;
            sample_reg   <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= sample_tick;
            if (sample_tick) begin
                adc_clock  <= 1'b0;
                sample_reg <= adc_data;
            end else if (counter == (div_eff >> 1)) begin
                adc_clock <= 1'b1;
            end
        end
    end

    assign crossing  = prev_ok && (prev_reg < trig_level) && (sample_reg >= trig_level);
    assign write_hit = sample_valid && ((state == FILL) || ((state == ARM) && crossing));

    assign wr.wr_en      = write_hit;
    assign wr.wr_address = address;
    assign wr.wr_data    = sample_reg;

    always_ff @(posedge clk_400M or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            address  <= '0;
            prev_reg <= '0;
            prev_ok  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (sample_valid) begin
                prev_reg <= sample_reg;
                prev_ok  <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        address <= '0;
                        busy    <= 1'b1;
                        if (trig_en) begin
                            state   <= ARM;
                            prev_ok <= 1'b0;   // first armed sample only primes the history
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                ARM: begin
                    if (write_hit) begin
                        address <= ADDR_W'(1);
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (sample_valid) begin
                        if (address == LAST_ADDR) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            address <= address + ADDR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_writer.sv
// Directed bench for adc_capture_writer: expected write addresses are queued at each
// start and consumed by a write monitor that also checks data, spacing and clock phase.
`timescale 1ns/1ps
module tb_adc_capture_writer;

    logic        clk_400M = 1'b0;
    logic        rst_n    = 1'b0;
    logic [23:0] div_in   = 24'd9;
    logic        start    = 1'b0;
    logic        trig_en  = 1'b0;
    logic [13:0] trig_level = 14'd0;
    logic [13:0] adc_data   = 14'd0;
    logic        adc_clock;
    logic        busy;
    logic        done;

    adc_capture_writer_if wr_bus ();

    adc_capture_writer dut (
        .clk_400M  (clk_400M),
        .rst_n     (rst_n),
        .div_in    (div_in),
        .start     (start),
        .trig_en   (trig_en),
        .trig_level(trig_level),
        .adc_data  (adc_data),
        .adc_clock (adc_clock),
        .wr        (wr_bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_400M = ~clk_400M;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_total = 0;
    int          done_total = 0;
    int          last_wr_cyc = -1000;
    int          exp_period = 10;
    int          skip_addr = -1;
    int          mon_addr;
    logic [13:0] prev_adc = 14'd0;
    logic        prev_aclk = 1'b0;
    logic [13:0] rec0_data = 14'd0;
    bit          ramp_mode = 1'b0;
    int          exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk_400M);
        cyc++;
    end

    // Write/done monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk_400M);
        if (rst_n) begin
            if (wr_bus.wr_en) begin
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                mon_addr = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                check("wr_address", 32'(wr_bus.wr_address), 32'(mon_addr));
                check("wr_data", 32'(wr_bus.wr_data), 32'(prev_adc));
                check("adc_clock_fall", 32'({prev_aclk, adc_clock}), 32'd2);
                if (mon_addr > 0 && mon_addr != skip_addr)
                    check("wr_spacing", 32'(cyc - last_wr_cyc), 32'(exp_period));
                if (mon_addr == 0) rec0_data = wr_bus.wr_data;
                last_wr_cyc = cyc;
                wr_total++;
            end
            if (done) begin
                done_total++;
                check("done_after_last", 32'(cyc - last_wr_cyc), 32'd1);
                check("done_queue_empty", 32'(exp_q.size()), 32'd0);
            end
        end
        prev_adc  = adc_data;
        prev_aclk = adc_clock;
    end

    task automatic step();
        @(posedge clk_400M);
        #1;
        if (ramp_mode) adc_data = adc_data + 14'd13;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic push_record();
        for (int i = 0; i < 2000; i++) exp_q.push_back(i);
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_total < target && n < budget) begin
            step();
            n++;
        end
        check("wait_wr_bound", 32'(wr_total >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_total < target && n < budget) begin
            step();
            n++;
        end
        check("wait_done_bound", 32'(done_total >= target), 32'd1);
    endtask

    task automatic measure(output int per, output int hi);
        int   r1 = -1;
        int   f  = -1;
        int   r2 = -1;
        int   n  = 0;
        logic last;
        last = adc_clock;
        while (r2 < 0 && n < 400) begin
            step();
            n++;
            if (!last && adc_clock) begin
                if (r1 < 0) r1 = cyc;
                else if (f >= 0) r2 = cyc;
            end else if (last && !adc_clock && r1 >= 0 && f < 0) begin
                f = cyc;
            end
            last = adc_clock;
        end
        check("measure_bound", 32'(r2 >= 0), 32'd1);
        per = r2 - r1;
        hi  = f - r1;
    endtask

    initial begin
        int per0, hi0, per1, hi1;
        int base_w, base_d, change_cyc;

        repeat (3) step();
        check("rst_adc_clock", 32'(adc_clock), 32'd0);
        check("rst_wr_en", 32'(wr_bus.wr_en), 32'd0);
        check("rst_wr_address", 32'(wr_bus.wr_address), 32'd0);
        check("rst_wr_data", 32'(wr_bus.wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Divider and sample clock shape
        measure(per0, hi0);
        check("div9_period", 32'(per0), 32'd10);
        check("div9_high", 32'(hi0), 32'd5);
        div_in = 24'd0;
        repeat (5) step();
        measure(per0, hi0);
        div_in = 24'd1;
        repeat (5) step();
        measure(per1, hi1);
        check("div0_period", 32'(per0), 32'd2);
        check("div0_high", 32'(hi0), 32'd1);
        check("div0_eq_div1_period", 32'(per0), 32'(per1));
        check("div0_eq_div1_high", 32'(hi0), 32'(hi1));

        // Immediate record with a stray start at write 500
        div_in = 24'd3;
        exp_period = 4;
        repeat (5) step();
        ramp_mode = 1'b1;
        base_w = wr_total;
        base_d = done_total;
        push_record();
        pulse_start();
        check("imm_busy", 32'(busy), 32'd1);
        wait_wr(base_w + 500, 5000);
        trig_en = 1'b1;
        pulse_start();
        trig_en = 1'b0;
        wait_done(base_d + 1, 10000);
        repeat (3) step();
        check("imm_writes", 32'(wr_total - base_w), 32'd2000);
        check("imm_one_done", 32'(done_total - base_d), 32'd1);
        check("imm_busy_after", 32'(busy), 32'd0);
        check("imm_queue_empty", 32'(exp_q.size()), 32'd0);

        // Trigger record: 100, 7999, 8000, 9000
        ramp_mode = 1'b0;
        adc_data = 14'd100;
        trig_level = 14'd8000;
        base_w = wr_total;
        base_d = done_total;
        push_record();
        trig_en = 1'b1;
        pulse_start();
        trig_en = 1'b0;
        repeat (8) step();
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_no_write_100", 32'(wr_total - base_w), 32'd0);
        adc_data = 14'd7999;
        repeat (4) step();
        check("arm_no_write_7999", 32'(wr_total - base_w), 32'd0);
        adc_data = 14'd8000;
        repeat (4) step();
        adc_data = 14'd9000;
        wait_done(base_d + 1, 10000);
        repeat (3) step();
        check("trig_first_data", 32'(rec0_data), 32'd8000);
        check("trig_writes", 32'(wr_total - base_w), 32'd2000);
        check("trig_one_done", 32'(done_total - base_d), 32'd1);

        // Constant 9000 above the threshold never crosses; reset is the only way out
        base_w = wr_total;
        trig_en = 1'b1;
        pulse_start();
        trig_en = 1'b0;
        repeat (40) step();
        check("const_no_write", 32'(wr_total - base_w), 32'd0);
        check("const_still_armed", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("const_rst_busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("const_idle_after_rst", 32'(busy), 32'd0);

        // Asynchronous reset at write 1000
        ramp_mode = 1'b1;
        exp_period = 4;
        base_w = wr_total;
        base_d = done_total;
        push_record();
        pulse_start();
        wait_wr(base_w + 1000, 10000);
        check("rst_at_1000_count", 32'(wr_total - base_w), 32'd1000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_bus.wr_en), 32'd0);
        check("mid_rst_wr_address", 32'(wr_bus.wr_address), 32'd0);
        check("mid_rst_wr_data", 32'(wr_bus.wr_data), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_adc_clock", 32'(adc_clock), 32'd0);
        exp_q.delete();
        repeat (20) step();
        rst_n = 1'b1;
        repeat (5) step();
        check("mid_rst_no_done", 32'(done_total - base_d), 32'd0);

        // Fresh record from address 0; divider drops from 100 to 5 after write 3
        div_in = 24'd100;
        exp_period = 101;
        base_w = wr_total;
        base_d = done_total;
        push_record();
        pulse_start();
        wait_wr(base_w + 3, 1000);
        repeat (50) step();
        div_in = 24'd5;
        change_cyc = cyc;
        exp_period = 6;
        skip_addr = 3;
        wait_wr(base_w + 4, 50);
        check("div_change_wrap", 32'(last_wr_cyc - change_cyc), 32'd7);
        wait_done(base_d + 1, 20000);
        repeat (3) step();
        check("div_change_writes", 32'(wr_total - base_w), 32'd2000);
        check("div_change_one_done", 32'(done_total - base_d), 32'd1);
        check("div_change_queue_empty", 32'(exp_q.size()), 32'd0);
        check("div_change_busy_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_capture_writer.md
# adc_capture_writer

Capture-side counterpart of the DDS playback path: generates the ADC sample clock from a programmable divider, registers ADC samples, and writes a 2000-entry waveform record into the shared 2048×14 wave RAM. The record start is either immediate or gated by a rising-edge level trigger. The written RAM is the same table format the DDS output stage reads: 11-bit address, 14-bit data, entries 0..1999.

## Interface
- DATA_W, 14, ADC/RAM sample width
- ADDR_W, 11, RAM address width
- REC_LEN, 2000, samples per record (last address REC_LEN-1 = 11'h7CF)
- clk_400M  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- div_in  in  24  sample period minus one, in clk_400M cycles; values 0 are treated as 1
- start  in  1  single-cycle arm request, honoured only in IDLE
- trig_en  in  1  1 = wait for level trigger, 0 = record immediately; sampled with start
- trig_level  in  14  unsigned trigger threshold
- adc_data  in  14  ADC output word, unsigned
- adc_clock  out  1  ADC sample clock
- wr_en  out  1  RAM write strobe, one cycle per sample
- wr_address  out  11  RAM write address
- wr_data  out  14  RAM write data
- busy  out  1  high in ARM and FILL
- done  out  1  one-cycle pulse when the record is complete

## Operation
- Divider: counter of 24 bits, reset 0. Let D = max(div_in, 1). If counter >= D, counter goes to 0; otherwise counter increments. Period = D+1 cycles. A change to div_in takes effect immediately through the >= compare.
- sample_tick = (counter == D). On the sample_tick edge, adc_data is registered into sample_reg. sample_valid is asserted for one cycle on the following cycle.
- adc_clock, registered: cleared to 0 on sample_tick and set to 1 when counter == (D>>1). Its falling edge therefore follows the sampling edge.
- prev_reg/prev_ok: on every sample_valid, prev_reg is loaded from sample_reg and prev_ok is set to 1. prev_ok is cleared on entry to ARM.
- A crossing is detected when prev_ok=1, prev_reg < trig_level, and sample_reg >= trig_level. The compare is unsigned and 14 bits wide.
- FSM (2-bit state), reset state IDLE:
  - IDLE: on start, go to ARM if trig_en=1, else go to FILL. wr_address is cleared to 0.
  - ARM: on sample_valid with a crossing, write sample_reg at address 0 in that same cycle, set the address to 1, and go to FILL. A sample_valid without a crossing produces no write.
  - FILL: on each sample_valid, wr_en=1 with the current address. After the write at address 1999, go to DONE; otherwise increment the address.
  - DONE: done=1 for one cycle, then go to IDLE.
- While busy, start is ignored. There is no abort input; rst_n is the only abort.
- wr_en, wr_address, and wr_data are combinational from the state, sample_valid, sample_reg, and the address register. wr_data always equals sample_reg.

## Timing
- Reset values: counter=0, adc_clock=0, sample_reg=0, prev_reg=0, prev_ok=0, state=IDLE, address=0, wr_en=0, wr_data=0, busy=0, done=0.
- Latency from the sampling edge to wr_en is 1 cycle.
- Writes are spaced exactly D+1 cycles apart.
- A record in FILL takes 2000 writes. done rises 1 cycle after the last write, at address 1999.
- Immediate mode: the first write is on the first sample_valid after FILL is entered.
- Trigger mode: at least 2 samples are needed after arming, because the first sample only primes prev_ok.
- start in the same cycle as sample_valid while in IDLE: no write. The FSM enters ARM/FILL on the next cycle.
- Reset asserted mid-record: all outputs go to their reset values asynchronously. RAM contents are left partial; no done pulse is issued.
- The address never exceeds 11'h7CF.

## Test plan
- Divider/clock: div_in=9 → writes every 10 cycles; adc_clock rises when counter==4 and falls when counter==9; div_in=0 gives the same timing as div_in=1.
- Immediate record: trig_en=0, div_in=3, adc_data ramp → exactly 2000 wr_en pulses at addresses 0..1999, each wr_data equal to adc_data at the prior tick; done one cycle after address 1999; busy low afterwards.
- Trigger: trig_en=1, trig_level=8000, samples 100, 7999, 8000, 9000 → first write is 8000 at address 0; no writes before it. A constant input of 9000 never triggers.
- start ignored while busy: pulse start at write 500 → the record continues unchanged and there is exactly one done pulse.
- Async reset at write 1000: outputs go to 0 immediately, the FSM is IDLE, no done; a new start records from address 0.
- div_in changed from 100 to 5 mid-record: the counter wraps on the next cycle if counter >= 5; subsequent writes are spaced 6 cycles apart; the address sequence stays contiguous.
